// File: rtl/my_mem.sv
// Single-port word memory with an even-parity bit stored alongside each word.
// Reads are registered (one-clock latency) and return the old word on a same-edge write.
module my_mem #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH:0]   data_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Power-up contents are zero; reset never touches the array.
   logic [DATA_WIDTH:0] mem [0:DEPTH-1] = '{default: '0};

   logic [DATA_WIDTH:0] dataOut_q;
   logic [DATA_WIDTH:0] dataOut_d;
   logic [DATA_WIDTH:0] wrWord;
   logic                wrEnable;

   always_comb begin
      wrWord    = {^data_in, data_in};
      wrEnable  = write & ~rst;
      dataOut_d = dataOut_q;
      if (read) begin
         dataOut_d = mem[address];
      end
   end

   // The read samples mem before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataOut_q <= '0;
      end else begin
         dataOut_q <= dataOut_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEnable) begin
         mem[address] <= wrWord;
      end
   end

   assign data_out = dataOut_q;

endmodule

// File: tb/tb_my_mem.sv
// Directed and randomised checks of my_mem at default parameters.
// Each stimulus step spans one rising edge; outputs are sampled 1ns after it.
module tb_my_mem;

   logic        clk;
   logic        rst;
   logic        write;
   logic        read;
   logic [7:0]  data_in;
   logic [15:0] address;
   logic [8:0]  data_out;

   int checkCount = 0;
   int passCount  = 0;

   logic [8:0]  model [int];
   logic [15:0] rndAddr [100];
   logic [7:0]  rndData [100];

   my_mem #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .write   (write),
      .read    (read),
      .data_in (data_in),
      .address (address),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                input logic [15:0] a, input logic [7:0] d);
      rst     = r;
      write   = w;
      read    = rd;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
      if (!r && w) begin
         model[int'(a)] = {^d, d};
      end
   endtask

   task automatic checkOutput(input string tag, input logic [8:0] observed,
                              input logic [8:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 9'h%03h, expected 9'h%03h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; write = 1'b0; read = 1'b0; address = '0; data_in = '0;

      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      checkOutput("reset_state", data_out, 9'h000);

      applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 8'h0F);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 8'h00);
      checkOutput("read_1234_even_parity", data_out, 9'h00F);

      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042, 8'h00);
      checkOutput("unwritten_reads_zero", data_out, 9'h000);

      applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h07);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h00);
      checkOutput("read_ffff_odd_parity", data_out, 9'h107);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF);
         checkOutput($sformatf("hold_cycle%0d", i), data_out, 9'h107);
      end

      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0005, 8'hAA);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 8'h01);
      checkOutput("rbw_old_data", data_out, 9'h0AA);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0005, 8'h00);
      checkOutput("rbw_new_data", data_out, 9'h101);

      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0009, 8'h3C);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0009, 8'h00);
      checkOutput("pre_reset_read", data_out, 9'h03C);
      // Reset with a write and read pending: both must be ignored.
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0009, 8'hFF);
      checkOutput("mid_reset_clears_out", data_out, 9'h000);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0009, 8'h00);
      checkOutput("post_reset_contents", data_out, 9'h03C);

      for (int i = 0; i < 100; i++) begin
         rndAddr[i] = 16'($urandom);
         rndData[i] = 8'($urandom);
         applyStimulus(1'b0, 1'b1, 1'b0, rndAddr[i], rndData[i]);
      end
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, rndAddr[i], 8'h00);
         checkOutput($sformatf("rand_read%0d_addr%04h", i, rndAddr[i]),
                     data_out, model[int'(rndAddr[i])]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/my_mem.md
MY_MEM -- requirements
Module: my_mem

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the address width; depth is 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of the write data; stored word width is DATA_WIDTH+1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port write, input, 1 bit: write enable.
REQ-007 The block SHALL have port read, input, 1 bit: read enable.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-009 The block SHALL have port address, input, ADDR_WIDTH bits: shared read/write word address.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH+1 bits: registered read data, {parity, data}.

Function
REQ-011 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH+1 bits each; 65536 x 9 at defaults.
REQ-012 On a rising edge with write=1, the word at address SHALL become {^data_in, data_in}.
REQ-013 The parity bit SHALL be the even-parity XOR of all data_in bits, stored in the MSB (bit DATA_WIDTH).
REQ-014 On a rising edge with read=1, data_out SHALL load the stored word at address; read latency is one clock.
REQ-015 When read=0, data_out SHALL hold its previous value.
REQ-016 When write=1 and read=1 on the same edge, the write SHALL occur and data_out SHALL load the old contents (read-before-write).
REQ-017 A write to an address already written SHALL overwrite it; the last write wins.
REQ-018 Every address value, 0 through 2**ADDR_WIDTH-1, SHALL be valid; there is no wrap-around or out-of-range case.
REQ-019 Array contents SHALL NOT be cleared by reset; unwritten locations read as 0 after power-up, since the array is initialised to zero.
REQ-020 With write=0 and read=0, no state other than hold SHALL change.

Reset
REQ-021 When rst=1 at a rising edge, data_out SHALL become 0 on that edge.
REQ-022 When rst=1, any read or write on that edge SHALL be ignored.
REQ-023 A reset mid-sequence SHALL NOT alter previously written array contents; reads after rst deasserts return the stored words.

Verification
REQ-024 The bench SHALL write data_in=8'h0F to address 16'h1234, then read 16'h1234; data_out SHALL equal 9'h00F one clock later, because parity of 8'h0F is 0.
REQ-025 The bench SHALL write 8'h07 to address 16'hFFFF, then read it; data_out SHALL equal 9'h107, because parity is 1.
REQ-026 The bench SHALL write 100 random address/data pairs back-to-back, one per clock, then read all 100 back-to-back; each data_out SHALL equal {^d,d} for the last data written to that address, with 0 mismatches.
REQ-027 The bench SHALL write 8'hAA to address 5, then on the same edge apply write=1, read=1, data_in=8'h01 at address 5; data_out SHALL be 9'h0AA, and a following read SHALL return 9'h101.
REQ-028 The bench SHALL write 8'h3C to address 9, read it so data_out=9'h03C, then assert rst for one clock; data_out SHALL become 0 and a subsequent read of address 9 SHALL return 9'h03C.
REQ-029 The bench SHALL drive read=0 for 3 clocks after a read; data_out SHALL stay unchanged.
